// File: rtl/typhoon_mem_pkg.sv
// Shared definitions for the Typhoon SRAM subsystem.
// Holds the SRAM word/address widths, the burst-reader state encoding,
// the request tag bits shared with the controller, and the burst address helper.
package typhoon_mem_pkg;

  localparam int SRAM_ADDR_W = 20;
  localparam int SRAM_DATA_W = 16;

  // Request tag bits understood by the controller's request ports.
  localparam logic [1:0] REQ_TAG_READ  = 2'b01;
  localparam logic [1:0] REQ_TAG_WRITE = 2'b10;

  typedef enum logic [2:0] {
    RD_IDLE,
    RD_ISSUE,
    RD_SETTLE,
    RD_WAIT,
    RD_DRAIN
  } reader_state_e;

  // Word address of beat idx within a burst; wraps naturally at the top of SRAM.
  function automatic logic [SRAM_ADDR_W-1:0] burst_addr(
    input logic [SRAM_ADDR_W-1:0] base,
    input logic [15:0]            idx
  );
    return base + {{(SRAM_ADDR_W-16){1'b0}}, idx};
  endfunction

endpackage

// File: rtl/sram_stream_fifo.sv
// Synchronous single-clock FIFO used to buffer words returned by the SRAM.
// Ports:
//   clk_i, rst_i   clock and synchronous active-high reset
//   push_i/wdata_i write one word (caller never pushes when full)
//   pop_i          drop the head word (caller never pops when empty)
//   flush_i        discard all contents; takes priority over push/pop
//   rdata_o        head word, forced to 0 while empty
//   count_o        number of stored words, 0..DEPTH
module sram_stream_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic                     flush_i,
  input  logic [WIDTH-1:0]         wdata_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q;

  // Storage carries no reset; emptiness is tracked by count_q alone.
  always_ff @(posedge clk_i) begin
    if (push_i) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

  // Pointers wrap for free because DEPTH is a power of two.
  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_i)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({push_i, pop_i})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign rdata_o = (count_q == '0) ? '0 : mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/sram_burst_reader.sv
// Burst read client for one request port of the dual-clock SRAM controller.
// Accepts a (BaseAddr, Length) command, issues one read request at a time,
// buffers returned words in a small FIFO and streams them out valid/ready.
// Ports:
//   BOARD_CLK, RESET             clock, synchronous active-high reset
//   Start, BaseAddr, Length      burst command (accepted only while idle)
//   Busy, Done, Error            status; Error is a sticky timeout flag
//   QueueReadReq, AddressToSRAM  read request to the controller
//   QueueWriteReq, DataToSRAM    unused write path, tied low
//   DataReady, DataFromSRAM      controller response
//   OutData, OutValid, OutReady  output word stream
module sram_burst_reader
  import typhoon_mem_pkg::*;
#(
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                   BOARD_CLK,
  input  logic                   RESET,
  input  logic                   Start,
  input  logic [SRAM_ADDR_W-1:0] BaseAddr,
  input  logic [15:0]            Length,
  output logic                   Busy,
  output logic                   Done,
  output logic                   Error,
  output logic                   QueueReadReq,
  output logic                   QueueWriteReq,
  output logic [SRAM_ADDR_W-1:0] AddressToSRAM,
  output logic [SRAM_DATA_W-1:0] DataToSRAM,
  input  logic                   DataReady,
  input  logic [SRAM_DATA_W-1:0] DataFromSRAM,
  output logic [SRAM_DATA_W-1:0] OutData,
  output logic                   OutValid,
  input  logic                   OutReady
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  reader_state_e          state_q, state_d;
  logic [SRAM_ADDR_W-1:0] base_q, base_d;
  logic [15:0]            len_q, len_d;
  logic [15:0]            idx_q, idx_d;
  logic [TW-1:0]          tmo_q, tmo_d;
  logic                   req_q, req_d;
  logic [SRAM_ADDR_W-1:0] addr_q, addr_d;
  logic                   done_q, done_d;
  logic                   err_q, err_d;

  logic          fifo_push, fifo_pop, fifo_flush;
  logic [CW-1:0] fifo_cnt;
  logic          fifo_space, last_word, tmo_hit, drain_empty;

  sram_stream_fifo #(
    .WIDTH (SRAM_DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (BOARD_CLK),
    .rst_i   (RESET),
    .push_i  (fifo_push),
    .pop_i   (fifo_pop),
    .flush_i (fifo_flush),
    .wdata_i (DataFromSRAM),
    .rdata_o (OutData),
    .count_o (fifo_cnt)
  );

  assign OutValid    = (fifo_cnt != '0);
  assign fifo_pop    = OutValid && OutReady;
  // Space is reserved at issue time so the returning word always has a slot.
  assign fifo_space  = (fifo_cnt < CW'(FIFO_DEPTH));
  assign last_word   = ((idx_q + 16'd1) == len_q);
  assign tmo_hit     = (tmo_q == TW'(TIMEOUT_CYCLES - 1));
  assign drain_empty = (fifo_cnt == '0) || ((fifo_cnt == CW'(1)) && fifo_pop);

  // State register and registered control outputs
  always_ff @(posedge BOARD_CLK) begin
    if (RESET) begin
      state_q <= RD_IDLE;
      req_q   <= 1'b0;
      addr_q  <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      addr_q  <= addr_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  // Burst bookkeeping; always (re)loaded before use, so no reset needed.
  always_ff @(posedge BOARD_CLK) begin
    base_q <= base_d;
    len_q  <= len_d;
    idx_q  <= idx_d;
    tmo_q  <= tmo_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RD_IDLE:   if (Start && (Length != '0)) state_d = RD_ISSUE;
      RD_ISSUE:  if (fifo_space) state_d = RD_SETTLE;
      RD_SETTLE: state_d = RD_WAIT;
      RD_WAIT: begin
        if (DataReady)    state_d = last_word ? RD_DRAIN : RD_ISSUE;
        else if (tmo_hit) state_d = RD_IDLE;
      end
      RD_DRAIN:  if (drain_empty) state_d = RD_IDLE;
      default:   state_d = RD_IDLE;
    endcase
  end

  // Output and datapath logic
  always_comb begin
    base_d     = base_q;
    len_d      = len_q;
    idx_d      = idx_q;
    tmo_d      = tmo_q;
    addr_d     = addr_q;
    err_d      = err_q;
    req_d      = 1'b0;
    done_d     = 1'b0;
    fifo_push  = 1'b0;
    fifo_flush = 1'b0;
    unique case (state_q)
      RD_IDLE: begin
        if (Start) begin
          base_d = BaseAddr;
          len_d  = Length;
          idx_d  = '0;
          err_d  = 1'b0;
          done_d = (Length == '0);
        end
      end
      RD_ISSUE: begin
        if (fifo_space) begin
          req_d  = 1'b1;
          addr_d = burst_addr(base_q, idx_q);
        end
      end
      RD_SETTLE: begin
        // DataReady may still be high from the previous request here.
        tmo_d = '0;
      end
      RD_WAIT: begin
        if (DataReady) begin
          fifo_push = 1'b1;
          idx_d     = idx_q + 16'd1;
        end else if (tmo_hit) begin
          err_d      = 1'b1;
          fifo_flush = 1'b1;
          done_d     = 1'b1;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      RD_DRAIN: begin
        if (drain_empty) done_d = 1'b1;
      end
      default: ;
    endcase
  end

  assign Busy          = (state_q != RD_IDLE);
  assign Done          = done_q;
  assign Error         = err_q;
  assign QueueReadReq  = req_q;
  assign AddressToSRAM = addr_q;
  assign QueueWriteReq = 1'b0;
  assign DataToSRAM    = '0;

endmodule

// File: doc/sram_burst_reader.md
# sram_burst_reader

Requester-side client for one port of the dual-clock SRAM controller, clocked on the board clock. It accepts a burst command (base address, length) and issues one controller read request at a time. It waits for the controller's DataReady, captures each returned word into a small internal FIFO, and presents the words to a downstream consumer as a valid/ready stream. It sits between a board-clock consumer (e.g. a scanline or texture fetch unit) and one of the four request ports of the SRAM controller.

## Interface
Parameters:
- FIFO_DEPTH, 4: output FIFO depth in words; power of two, ≥2.
- TIMEOUT_CYCLES, 255: maximum cycles spent in WAIT before the burst is aborted.

Ports:
- BOARD_CLK  in  1  sole clock for all logic.
- RESET  in  1  synchronous, active-high reset.
- Start  in  1  one-cycle burst command strobe.
- BaseAddr  in  20  first SRAM word address; sampled when Start is accepted.
- Length  in  16  number of words to read; sampled when Start is accepted.
- Busy  out  1  high from accepted Start until Done.
- Done  out  1  one-cycle completion pulse.
- Error  out  1  sticky timeout flag; cleared on the next accepted Start.
- QueueReadReq  out  1  read request strobe to the controller port.
- QueueWriteReq  out  1  tied 0.
- AddressToSRAM  out  20  request address; valid while QueueReadReq=1.
- DataToSRAM  out  16  tied 0.
- DataReady  in  1  controller data-ready flag.
- DataFromSRAM  in  16  controller read data.
- OutData  out  16  FIFO head word.
- OutValid  out  1  FIFO not empty.
- OutReady  in  1  consumer accepts the head word.

## Operation
- FSM states: IDLE, ISSUE, SETTLE, WAIT, DRAIN.
- IDLE:
  - Start=1 latches BaseAddr, Length, and index=0, and clears Error.
  - Length=0 → Done pulses next cycle; no requests are issued; FSM stays IDLE.
  - Otherwise → ISSUE.
  - Start is ignored in every state except IDLE.
- ISSUE:
  - Entered only when the FIFO count is less than FIFO_DEPTH; otherwise the FSM stalls in ISSUE with QueueReadReq=0.
  - When issuing, QueueReadReq=1 for exactly one cycle, with AddressToSRAM = (BaseAddr + index) mod 2^20, i.e. the address wraps at 0xFFFFF→0x00000.
  - Next state is SETTLE.
- SETTLE:
  - One cycle. DataReady is ignored because the controller may still show a stale high from the previous request.
  - Next state is WAIT.
- WAIT:
  - DataReady=1 → DataFromSRAM is pushed into the FIFO on that edge and index is incremented.
  - If index+1 = Length → DRAIN; else → ISSUE.
  - The timeout counter increments on every WAIT cycle. When it reaches TIMEOUT_CYCLES: set Error, flush the FIFO, pulse Done, → IDLE.
- DRAIN:
  - When the FIFO is empty (or becomes empty by the pop on this edge), Done pulses and the FSM → IDLE.
- Only one request is ever outstanding. FIFO space is checked at ISSUE time, so the returning word always has a slot.
- FIFO behaviour:
  - A pop occurs when OutValid && OutReady.
  - A simultaneous push and pop leaves the count unchanged.
  - A push is never attempted when full.
- Busy = (state ≠ IDLE).

## Timing
- Reset values: Busy=0, Done=0, Error=0, QueueReadReq=0, AddressToSRAM=0, OutValid=0, OutData=0, FIFO empty, state=IDLE.
- RESET mid-burst abandons the burst. Any in-flight controller data is dropped, and no Done pulse is produced.
- Registered outputs: QueueReadReq, AddressToSRAM, Done, Error.
- Minimum cost is 3 cycles per word (ISSUE, SETTLE, WAIT with DataReady=1).
- A pushed word appears on OutData/OutValid the cycle after the push edge.
- Done is asserted on the edge after the last pop, or on the edge where the last word leaves in DRAIN.

## Structure
- Shared package typhoon_mem_pkg holds:
  - SRAM_ADDR_W=20 and SRAM_DATA_W=16;
  - the reader state enum;
  - the port request-encoding constants (read/write tag bits) shared with the controller.
- Sub-module sram_stream_fifo: synchronous single-clock FIFO (push, pop, count, flush), parameterised on width and depth.

## Test plan
- Start, BaseAddr=0x00100, Length=4; controller model returns 0xA000+addr after 2 cycles; OutReady=1 → reads at addresses 0x100–0x103; outputs 0xA100–0xA103 in order; one Done pulse; Error=0.
- Start, BaseAddr=0xFFFFE, Length=4 → request addresses FFFFE, FFFFF, 00000, 00001.
- Length=8, FIFO_DEPTH=4, OutReady=0 → exactly 4 requests, then stalls in ISSUE with no QueueReadReq. Raising OutReady resumes the burst; all 8 words arrive in order.
- Controller never asserts DataReady, TIMEOUT_CYCLES=16 → Error=1 and Done pulses 16 cycles after entering WAIT; FIFO empty; Busy=0; the next Start clears Error.
- Start with Length=0 → Done the next cycle; QueueReadReq never asserted. Start pulsed while Busy → ignored; the burst count is unchanged.
- RESET asserted mid-WAIT → the next cycle shows all outputs at reset values; a subsequent DataReady produces no push.
